// File: rtl/rv32i_hazard_ctrl.sv
// rv32i_hazard_ctrl
//   Hazard / sequencing controller for a 5-stage RV32I pipeline.
//   Tracks destination info of the instructions in EX, MEM and WB in a small
//   scoreboard and from it produces the front-end enables, the IF/ID flush,
//   the ID/EX bubble, the EX forwarding selects and the ID write-back bypass.
//   Three saturating counters record stall, redirect and freeze cycles.
// Ports
//   i_clk, i_reset            clock, async active-high reset
//   i_id_*                    decoded info of the instruction in ID
//   i_ex_redirect             EX resolved a taken control transfer
//   i_mem_busy                data memory not ready, whole pipe freezes
//   o_pc_en, o_ifid_en        front-end load enables
//   o_flush_ifid              IF/ID loads a bubble
//   o_idex_bubble             ID/EX loads a bubble
//   o_fwd_a, o_fwd_b          00 ID/EX data, 01 EX/MEM aluout, 10 WB rd_data
//   o_id_byp_a, o_id_byp_b    ID operand takes WB rd_data
//   o_stall_cnt/flush/freeze  performance counters
module rv32i_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_regwrite,
  input  logic              i_id_memtoreg,
  input  logic              i_ex_redirect,
  input  logic              i_mem_busy,
  output logic              o_pc_en,
  output logic              o_ifid_en,
  output logic              o_flush_ifid,
  output logic              o_idex_bubble,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b,
  output logic              o_id_byp_a,
  output logic              o_id_byp_b,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt,
  output logic [CNT_W-1:0]  o_freeze_cnt
);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              mtr;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } slot_t;

  typedef enum logic [1:0] {RUN, LU_STALL, REDIR, FROZEN} state_t;

  slot_t            r_ex, r_mem, r_wb, w_ex_nxt;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_freeze_cnt;
  logic             w_load_use;

  // Slot really writes a register other than x0.
  function automatic logic f_wr(input slot_t s);
    return s.v & s.rw & (s.rd != '0);
  endfunction

  // MEM beats WB; a load in MEM is never a source (load-use stall covers it).
  function automatic logic [1:0] f_fwd(input slot_t ex, input slot_t mem,
                                       input slot_t wb, input logic [REG_AW-1:0] rs);
    if (!ex.v)                                   return 2'b00;
    if (f_wr(mem) && !mem.mtr && mem.rd == rs)   return 2'b01;
    if (f_wr(wb) && wb.rd == rs)                 return 2'b10;
    return 2'b00;
  endfunction

  // After a stall the load has left EX, so the state term never fires in
  // practice; it only guarantees one bubble per load.
  assign w_load_use = f_wr(r_ex) & r_ex.mtr & i_id_valid & (r_state != LU_STALL) &
                      ((i_id_use_rs1 & (i_id_rs1 == r_ex.rd)) |
                       (i_id_use_rs2 & (i_id_rs2 == r_ex.rd)));

  always_comb begin
    o_pc_en       = 1'b1;
    o_ifid_en     = 1'b1;
    o_flush_ifid  = 1'b0;
    o_idex_bubble = 1'b0;
    o_fwd_a       = f_fwd(r_ex, r_mem, r_wb, r_ex.rs1);
    o_fwd_b       = f_fwd(r_ex, r_mem, r_wb, r_ex.rs2);
    o_id_byp_a    = f_wr(r_wb) & i_id_use_rs1 & (r_wb.rd == i_id_rs1);
    o_id_byp_b    = f_wr(r_wb) & i_id_use_rs2 & (r_wb.rd == i_id_rs2);
    w_state_nxt   = RUN;
    if (i_reset) begin
      o_pc_en       = 1'b0;
      o_ifid_en     = 1'b0;
      o_flush_ifid  = 1'b1;
      o_idex_bubble = 1'b1;
      o_fwd_a       = 2'b00;
      o_fwd_b       = 2'b00;
      o_id_byp_a    = 1'b0;
      o_id_byp_b    = 1'b0;
    end else if (i_mem_busy) begin
      // redirect is ignored here; EX holds, so it is seen again on release
      o_pc_en     = 1'b0;
      o_ifid_en   = 1'b0;
      w_state_nxt = FROZEN;
    end else if (i_ex_redirect) begin
      o_flush_ifid  = 1'b1;
      o_idex_bubble = 1'b1;
      w_state_nxt   = REDIR;
    end else if (w_load_use) begin
      o_pc_en       = 1'b0;
      o_ifid_en     = 1'b0;
      o_idex_bubble = 1'b1;
      w_state_nxt   = LU_STALL;
    end
  end

  always_comb begin
    w_ex_nxt = '0;
    if (i_id_valid && !o_idex_bubble)
      w_ex_nxt = '{v: 1'b1, rd: i_id_rd, rw: i_id_regwrite, mtr: i_id_memtoreg,
                   rs1: i_id_rs1, rs2: i_id_rs2};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ex         <= '0;
      r_mem        <= '0;
      r_wb         <= '0;
      r_state      <= RUN;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_freeze_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!i_mem_busy) begin
        r_wb  <= r_mem;
        r_mem <= r_ex;
        r_ex  <= w_ex_nxt;
      end
      case (w_state_nxt)
        LU_STALL: if (r_stall_cnt  != '1) r_stall_cnt  <= r_stall_cnt  + 1'b1;
        REDIR:    if (r_flush_cnt  != '1) r_flush_cnt  <= r_flush_cnt  + 1'b1;
        FROZEN:   if (r_freeze_cnt != '1) r_freeze_cnt <= r_freeze_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign o_stall_cnt  = r_stall_cnt;
  assign o_flush_cnt  = r_flush_cnt;
  assign o_freeze_cnt = r_freeze_cnt;

endmodule
